cam_pipe: RTL and testbench

- Parametrised, pipelined content-addressable memory (CAM) with per-entry valid bits, invalidate/flush, and lowest-index priority hit resolution.
- Successor to the 32x32 single-cycle CAM. Width and depth are generic.
- Search path is registered in two stages so it closes timing at larger DEPTH.
- Sits between the lookup-issuing logic and the data tables; the search index it returns addresses the companion RAM.

---
 rtl/cam_pipe.sv | 196 +++++++++++++++++++
 tb/tb_cam_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pipe.sv
// cam_pipe: parametrised, pipelined content-addressable memory.
//
// Each entry holds a WIDTH-bit word and a valid bit. The entries can be read
// by index, written, invalidated, or flushed. A search compares a key against
// every valid entry. It returns the lowest matching index, a hit flag and a
// multiple-match flag. The index addresses the companion data RAM.
//
// Search pipeline:
//   edge N   : the match vector is captured from pre-edge contents. A write
//              on the same edge is not seen.
//   edge N+1 : a priority encode of the captured vector is registered. The
//              result appears on the search_* outputs.
//
// Reads take one cycle. Read, write, invalidate and search are independent
// and can all happen in the same cycle.
//
// Optional feature (macro CAM_TERNARY_EN):
//   defined   - a per-entry care mask is stored with every write. The mask
//               resets to all-ones. Bits whose mask is 0 are not compared.
//   undefined - there is no mask storage, write_mask_i is ignored, and the
//               compare is an exact match.
//
// Ports:
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   read_enable_i   read request
//   read_index_i    entry to read
//   write_enable_i  write request (sets the entry valid)
//   write_index_i   entry to write / invalidate
//   write_data_i    data to store
//   write_mask_i    per-bit care mask, 1 = compare (ternary build only)
//   invalidate_i    clear valid of write_index_i
//   flush_i         clear all valid bits
//   search_enable_i search request
//   search_data_i   search key
//   read_valid_o    read result valid
//   read_value_o    read data (0 when not valid)
//   search_valid_o  one-cycle pulse per accepted search
//   search_hit_o    at least one entry matched
//   search_multi_o  more than one entry matched
//   search_index_o  lowest matching index (0 on miss)

module cam_pipe #(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  read_enable_i,
  input  logic [ADDR_WIDTH-1:0] read_index_i,
  input  logic                  write_enable_i,
  input  logic [ADDR_WIDTH-1:0] write_index_i,
  input  logic [WIDTH-1:0]      write_data_i,
  input  logic [WIDTH-1:0]      write_mask_i,
  input  logic                  invalidate_i,
  input  logic                  flush_i,
  input  logic                  search_enable_i,
  input  logic [WIDTH-1:0]      search_data_i,
  output logic                  read_valid_o,
  output logic [WIDTH-1:0]      read_value_o,
  output logic                  search_valid_o,
  output logic                  search_hit_o,
  output logic                  search_multi_o,
  output logic [ADDR_WIDTH-1:0] search_index_o
);

  // Storage and state
  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  logic             s1_valid_q;
  logic [DEPTH-1:0] s1_match_q;
  logic [DEPTH-1:0] match_d;

  logic                  enc_hit;
  logic                  enc_multi;
  logic [ADDR_WIDTH-1:0] enc_index;

  logic write_ok;
  logic read_ok;
  logic read_hit;

  // With a DEPTH that is not a power of two, some index codes have no entry
  // behind them. Those codes must never reach the storage arrays.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
    return 32'(idx) < 32'(DEPTH);
  endfunction

  assign write_ok = in_range(write_index_i);
  assign read_ok  = in_range(read_index_i);
  assign read_hit = read_enable_i && read_ok && valid_q[read_index_i];

`ifdef CAM_TERNARY_EN
  logic [WIDTH-1:0] mask_q [DEPTH];

  // The care masks reset to all-ones, so an entry that was never written
  // behaves as an exact-match entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mask_q[i] <= '1;
      end
    end else if (write_enable_i && write_ok) begin
      mask_q[write_index_i] <= write_mask_i;
    end
  end
`else
  logic [WIDTH-1:0] unused_mask;
  assign unused_mask = write_mask_i;
`endif

  // The entry data has no reset. It is only meaningful while valid is set.
  always_ff @(posedge clk_i) begin
    if (write_enable_i && write_ok) begin
      entry_q[write_index_i] <= write_data_i;
    end
  end

  // Flush beats invalidate. A write is applied last, so it re-validates its
  // own entry even when a flush or invalidate happens in the same cycle.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (invalidate_i && write_ok) begin
      valid_d[write_index_i] = 1'b0;
    end
    if (write_enable_i && write_ok) begin
      valid_d[write_index_i] = 1'b1;
    end
  end

  // Match vector, computed from pre-edge contents.
  always_comb begin
    match_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef CAM_TERNARY_EN
      match_d[i] = valid_q[i] &&
                   (((entry_q[i] ^ search_data_i) & mask_q[i]) == '0);
`else
      match_d[i] = valid_q[i] && (entry_q[i] == search_data_i);
`endif
    end
  end

  // Priority encoder: keep the first set bit from index 0 upward. Flag a
  // second set bit as a multi-match.
  always_comb begin
    enc_hit   = 1'b0;
    enc_multi = 1'b0;
    enc_index = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (s1_match_q[i]) begin
        if (enc_hit) begin
          enc_multi = 1'b1;
        end else begin
          enc_hit   = 1'b1;
          enc_index = ADDR_WIDTH'(i);
        end
      end
    end
  end

  // Valid bits, the read port and both search stages. The captured match
  // vector is unaffected by a later flush, so a search that is in flight
  // reports what it saw.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q        <= '0;
      read_valid_o   <= 1'b0;
      read_value_o   <= '0;
      s1_valid_q     <= 1'b0;
      s1_match_q     <= '0;
      search_valid_o <= 1'b0;
      search_hit_o   <= 1'b0;
      search_multi_o <= 1'b0;
      search_index_o <= '0;
    end else begin
      valid_q <= valid_d;

      read_valid_o <= read_hit;
      read_value_o <= read_hit ? entry_q[read_index_i] : '0;

      s1_valid_q <= search_enable_i;
      s1_match_q <= search_enable_i ? match_d : '0;

      search_valid_o <= s1_valid_q;
      search_hit_o   <= s1_valid_q && enc_hit;
      search_multi_o <= s1_valid_q && enc_multi;
      search_index_o <= s1_valid_q ? enc_index : '0;
    end
  end

endmodule

// File: tb/tb_cam_pipe.sv
// tb_cam_pipe: randomized, self-checking bench for cam_pipe.
//
// The bench uses a 12-entry instance, which is not a power of two, so the
// index codes 12..15 exercise the out-of-range handling. A reference model
// (arrays plus a two-deep expected-result pipeline) predicts every output
// on every cycle. The CAM_TERNARY_EN macro selects the ternary compare rule
// in the model as well as in the design.

module tb_cam_pipe;

  localparam int WIDTH = 32;
  localparam int DEPTH = 12;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             read_enable;
  logic [AW-1:0]    read_index;
  logic             write_enable;
  logic [AW-1:0]    write_index;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic             invalidate;
  logic             flush;
  logic             search_enable;
  logic [WIDTH-1:0] search_data;
  logic             read_valid;
  logic [WIDTH-1:0] read_value;
  logic             search_valid;
  logic             search_hit;
  logic             search_multi;
  logic [AW-1:0]    search_index;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] m_data  [DEPTH];
  logic [WIDTH-1:0] m_mask  [DEPTH];
  bit               m_valid [DEPTH];
  bit               exp_rv;
  logic [WIDTH-1:0] exp_rval;
  bit               s1_v, s1_h, s1_m, s2_v, s2_h, s2_m;
  int               s1_i, s2_i;

  cam_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .read_enable_i  (read_enable),
    .read_index_i   (read_index),
    .write_enable_i (write_enable),
    .write_index_i  (write_index),
    .write_data_i   (write_data),
    .write_mask_i   (write_mask),
    .invalidate_i   (invalidate),
    .flush_i        (flush),
    .search_enable_i(search_enable),
    .search_data_i  (search_data),
    .read_valid_o   (read_valid),
    .read_value_o   (read_value),
    .search_valid_o (search_valid),
    .search_hit_o   (search_hit),
    .search_multi_o (search_multi),
    .search_index_o (search_index)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_mask[i]  = '1;
    end
    exp_rv = 0; exp_rval = '0;
    s1_v = 0; s1_h = 0; s1_m = 0; s1_i = 0;
    s2_v = 0; s2_h = 0; s2_m = 0; s2_i = 0;
  endtask

  // Apply the CAM rule to the model contents: count the matching entries
  // and record the first one.
  task automatic modelSearch(input logic [WIDTH-1:0] key, output bit h,
                             output bit m, output int idx);
    int count = 0;
    idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bit hit_i;
`ifdef CAM_TERNARY_EN
      hit_i = m_valid[i] && (((m_data[i] ^ key) & m_mask[i]) == '0);
`else
      hit_i = m_valid[i] && (m_data[i] == key);
`endif
      if (hit_i) begin
        if (count == 0) idx = i;
        count++;
      end
    end
    h = (count > 0);
    m = (count > 1);
  endtask

  task automatic checkAll();
    checkOutput("read_valid",   32'(read_valid),   32'(exp_rv));
    checkOutput("read_value",   read_value,        exp_rval);
    checkOutput("search_valid", 32'(search_valid), 32'(s2_v));
    checkOutput("search_hit",   32'(search_hit),   32'(s2_h));
    checkOutput("search_multi", 32'(search_multi), 32'(s2_m));
    checkOutput("search_index", 32'(search_index), 32'(s2_i));
  endtask

  task automatic driveIdle();
    read_enable = 0; read_index = '0; write_enable = 0; write_index = '0;
    write_data = '0; write_mask = '1; invalidate = 0; flush = 0;
    search_enable = 0; search_data = '0;
  endtask

  // One clock cycle: drive the inputs, advance the model across the edge,
  // then check every output.
  task automatic applyStimulus(input bit re, input int ridx, input bit we,
                               input int widx, input logic [WIDTH-1:0] wdata,
                               input logic [WIDTH-1:0] wmask, input bit inv,
                               input bit fl, input bit se,
                               input logic [WIDTH-1:0] key);
    bit h, m;
    int idx;
    read_enable = re; read_index = AW'(ridx);
    write_enable = we; write_index = AW'(widx);
    write_data = wdata; write_mask = wmask;
    invalidate = inv; flush = fl;
    search_enable = se; search_data = key;
    @(posedge clk);
    #1;
    if (re && ridx < DEPTH && m_valid[ridx]) begin
      exp_rv = 1; exp_rval = m_data[ridx];
    end else begin
      exp_rv = 0; exp_rval = '0;
    end
    s2_v = s1_v; s2_h = s1_h; s2_m = s1_m; s2_i = s1_i;
    if (se) begin
      modelSearch(key, h, m, idx);
      s1_v = 1; s1_h = h; s1_m = m; s1_i = h ? idx : 0;
    end else begin
      s1_v = 0; s1_h = 0; s1_m = 0; s1_i = 0;
    end
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end else if (inv && widx < DEPTH) begin
      m_valid[widx] = 1'b0;
    end
    if (we && widx < DEPTH) begin
      m_valid[widx] = 1'b1;
      m_data[widx]  = wdata;
      m_mask[widx]  = wmask;
    end
    checkAll();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, '0, '1, 0, 0, 0, '0);
  endtask

  task automatic writeEntry(input int idx, input logic [WIDTH-1:0] d);
    applyStimulus(0, 0, 1, idx, d, '1, 0, 0, 0, '0);
  endtask

  task automatic searchKey(input logic [WIDTH-1:0] key);
    applyStimulus(0, 0, 0, 0, '0, '1, 0, 0, 1, key);
  endtask

  task automatic readEntry(input int idx);
    applyStimulus(1, idx, 0, 0, '0, '1, 0, 0, 0, '0);
  endtask

  // The reset is asserted and released between clock edges, so any search
  // still in flight is cut off.
  task automatic resetPulse();
    driveIdle();
    #3;
    rst_n = 0;
    modelReset();
    #2;
    checkAll();
    #1;
    rst_n = 1;
  endtask

  initial begin
    clk = 0;
    rst_n = 0;
    driveIdle();
    modelReset();
    for (int i = 0; i < DEPTH; i++) m_data[i] = '0;
    #2;
    checkAll();
    @(posedge clk);
    #1;
    rst_n = 1;

    // Search in an empty CAM
    searchKey(32'h0);
    idleCycle();
    checkOutput("tp_empty_valid", 32'(search_valid), 32'd1);
    checkOutput("tp_empty_hit",   32'(search_hit),   32'd0);

    // Write, then read back
    writeEntry(3, 32'hDEADBEEF);
    readEntry(3);
    checkOutput("tp_read_valid", 32'(read_valid), 32'd1);
    checkOutput("tp_read_value", read_value, 32'hDEADBEEF);

    // Multi-match, then invalidate the lower entry
    writeEntry(5, 32'h1234);
    writeEntry(9, 32'h1234);
    searchKey(32'h1234);
    idleCycle();
    checkOutput("tp_multi_hit",   32'(search_hit),   32'd1);
    checkOutput("tp_multi_multi", 32'(search_multi), 32'd1);
    checkOutput("tp_multi_index", 32'(search_index), 32'd5);
    applyStimulus(0, 0, 0, 5, '0, '1, 1, 0, 0, '0);
    searchKey(32'h1234);
    idleCycle();
    checkOutput("tp_inv_hit",   32'(search_hit),   32'd1);
    checkOutput("tp_inv_multi", 32'(search_multi), 32'd0);
    checkOutput("tp_inv_index", 32'(search_index), 32'd9);

    // A write and a search on the same edge, then back-to-back searches
    applyStimulus(0, 0, 1, 7, 32'hAA, '1, 0, 0, 1, 32'hAA);
    searchKey(32'hAA);
    checkOutput("tp_same_edge_valid", 32'(search_valid), 32'd1);
    checkOutput("tp_same_edge_hit",   32'(search_hit),   32'd0);
    idleCycle();
    checkOutput("tp_next_valid", 32'(search_valid), 32'd1);
    checkOutput("tp_next_hit",   32'(search_hit),   32'd1);
    checkOutput("tp_next_index", 32'(search_index), 32'd7);

    // Flush while a search is in stage 1
    searchKey(32'h1234);
    applyStimulus(0, 0, 0, 0, '0, '1, 0, 1, 0, '0);
    checkOutput("tp_flush_inflight_hit",   32'(search_hit),   32'd1);
    checkOutput("tp_flush_inflight_index", 32'(search_index), 32'd9);
    searchKey(32'h1234);
    idleCycle();
    checkOutput("tp_flush_after_hit", 32'(search_hit), 32'd0);

    // Out-of-range write and read, write with invalidate, flush with write
    applyStimulus(0, 0, 1, 13, 32'h5555, '1, 0, 0, 0, '0);
    readEntry(13);
    checkOutput("tp_oor_valid", 32'(read_valid), 32'd0);
    checkOutput("tp_oor_value", read_value, 32'd0);
    applyStimulus(0, 0, 1, 4, 32'h44, '1, 1, 0, 0, '0);
    readEntry(4);
    checkOutput("tp_wr_inv_valid", 32'(read_valid), 32'd1);
    applyStimulus(0, 0, 1, 1, 32'h11, '1, 0, 1, 0, '0);
    readEntry(4);
    checkOutput("tp_flush_clears", 32'(read_valid), 32'd0);
    readEntry(1);
    checkOutput("tp_flush_write_valid", 32'(read_valid), 32'd1);

    // Reset while a search is in flight
    writeEntry(6, 32'h66);
    searchKey(32'h66);
    resetPulse();
    idleCycle();
    checkOutput("tp_reset_no_pulse0", 32'(search_valid), 32'd0);
    idleCycle();
    checkOutput("tp_reset_no_pulse1", 32'(search_valid), 32'd0);

    // Partial key match (only counts as a hit in the ternary build)
    applyStimulus(0, 0, 1, 2, 32'hAB00, 32'hFF00, 0, 0, 0, '0);
    searchKey(32'hABCD);
    idleCycle();
`ifdef CAM_TERNARY_EN
    checkOutput("tp_ternary_hit",   32'(search_hit),   32'd1);
    checkOutput("tp_ternary_index", 32'(search_index), 32'd2);
`else
    checkOutput("tp_exact_miss", 32'(search_hit), 32'd0);
`endif

    // Random traffic over a small key space, so that hits and multi-hits
    // are common
    for (int n = 0; n < 600; n++) begin
      bit re, we, inv, fl, se;
      int ridx, widx;
      logic [WIDTH-1:0] wd, wm, key;
      re   = ($urandom_range(0, 1) == 1);
      ridx = $urandom_range(0, 15);
      we   = ($urandom_range(0, 2) == 0);
      widx = $urandom_range(0, 15);
      wd   = 32'h100 + 32'($urandom_range(0, 3));
      wm   = ($urandom_range(0, 1) == 1) ? '1 : $urandom();
      inv  = ($urandom_range(0, 4) == 0);
      fl   = ($urandom_range(0, 40) == 0);
      se   = ($urandom_range(0, 2) != 0);
      key  = 32'h100 + 32'($urandom_range(0, 3));
      applyStimulus(re, ridx, we, widx, wd, wm, inv, fl, se, key);
      if (n == 300) resetPulse();
    end

    idleCycle();
    idleCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
